// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction memory and its load controller.
package instr_mem_pkg;

  localparam logic [31:0] IM_NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } im_state_t;

endpackage

// File: rtl/im_load_ctrl.sv
// EMPTY/LOAD/RUN sequencer and sequential write pointer for the program-load port.
module im_load_ctrl
  import instr_mem_pkg::*;
#(
  parameter int unsigned AWIDTH = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic              load_last,
  output im_state_t         state,
  output logic              wr_en_c,
  output logic [AWIDTH-1:0] wr_addr_c,
  output logic              load_ready,
  output logic              load_done,
  output logic [AWIDTH:0]   load_count
);

  im_state_t         state_q, state_d;
  logic [AWIDTH:0]   count_q, count_d;
  logic              finish_q, finish_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      count_q  <= '0;
      finish_q <= 1'b0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      finish_q <= finish_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  // A load ends on load_last or on the top index; the pointer never wraps.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    finish_d  = 1'b0;
    wr_en_c   = 1'b0;
    wr_addr_c = count_q[AWIDTH-1:0];
    unique case (state_q)
      EMPTY, RUN: begin
        if (load_start) begin
          state_d = LOAD;
          count_d = '0;
        end
      end
      LOAD: begin
        if (load_valid) begin
          wr_en_c = 1'b1;
          count_d = count_q + (AWIDTH+1)'(1);
          if (load_last || (count_q[AWIDTH-1:0] == {AWIDTH{1'b1}})) begin
            state_d  = RUN;
            finish_d = 1'b1;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
    ready_d = (state_d == LOAD);
    done_d  = finish_q;
  end

  assign state      = state_q;
  assign load_ready = ready_q;
  assign load_done  = done_q;
  assign load_count = count_q;

endmodule

// File: rtl/instr_mem_32bit.sv
// Instruction memory with one-cycle registered fetch and a sequential program-load port.
module instr_mem_32bit
  import instr_mem_pkg::*;
#(
  parameter int unsigned       AWIDTH   = 6,
  parameter int unsigned       RWIDTH   = 32,
  parameter logic [RWIDTH-1:0] NOP_WORD = RWIDTH'(IM_NOP_WORD)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] addr,
  output logic [RWIDTH-1:0] read_data,
  output logic              read_valid,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic              load_last,
  input  logic [RWIDTH-1:0] load_data,
  output logic              load_ready,
  output logic              load_done,
  output logic [AWIDTH:0]   load_count
);

  logic [RWIDTH-1:0] mem [2**AWIDTH];

  im_state_t         state;
  logic              wr_en_c;
  logic [AWIDTH-1:0] wr_addr_c;
  logic [RWIDTH-1:0] read_data_q, read_data_d;
  logic              read_valid_q, read_valid_d;

  im_load_ctrl #(.AWIDTH(AWIDTH)) u_load_ctrl (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_last  (load_last),
    .state      (state),
    .wr_en_c    (wr_en_c),
    .wr_addr_c  (wr_addr_c),
    .load_ready (load_ready),
    .load_done  (load_done),
    .load_count (load_count)
  );

  // Array contents survive reset; visibility is controlled by load_count.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wr_addr_c] <= load_data;
    end
  end

  always_comb begin
    read_data_d  = NOP_WORD;
    read_valid_d = 1'b0;
    if (state == RUN) begin
      read_valid_d = 1'b1;
      if ({1'b0, addr} < load_count) begin
        read_data_d = mem[addr];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data_q  <= NOP_WORD;
      read_valid_q <= 1'b0;
    end else begin
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
    end
  end

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;

endmodule

// File: tb/tb_instr_mem_32bit.sv
// Directed, table-driven bench for instr_mem_32bit.
module tb_instr_mem_32bit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  addr = '0;
  logic [31:0] read_data;
  logic        read_valid;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_last = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_ready;
  logic        load_done;
  logic [6:0]  load_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
    logic        valid;
  } vec_t;

  vec_t rd3  [6];
  vec_t rd64 [4];

  instr_mem_32bit dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .read_data  (read_data),
    .read_valid (read_valid),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_last  (load_last),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_done  (load_done),
    .load_count (load_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_reads(input vec_t v, input string tag);
    addr = v.addr;
    tick();
    chk({tag, "_data"}, 64'(read_data), 64'(v.data));
    chk({tag, "_valid"}, 64'(read_valid), 64'(v.valid));
  endtask

  initial begin
    rd3[0] = '{6'd0,  32'h1111_1111, 1'b1};
    rd3[1] = '{6'd1,  32'h2222_2222, 1'b1};
    rd3[2] = '{6'd2,  32'h3333_3333, 1'b1};
    rd3[3] = '{6'd3,  32'h0000_0000, 1'b1};
    rd3[4] = '{6'd5,  32'h0000_0000, 1'b1};
    rd3[5] = '{6'd63, 32'h0000_0000, 1'b1};
    rd64[0] = '{6'd63, 32'd63, 1'b1};
    rd64[1] = '{6'd0,  32'd0,  1'b1};
    rd64[2] = '{6'd32, 32'd32, 1'b1};
    rd64[3] = '{6'd1,  32'd1,  1'b1};

    // Reset and idle
    #2;
    chk("rst_read_valid", 64'(read_valid), 64'd0);
    chk("rst_load_count", 64'(load_count), 64'd0);
    tick();
    rst = 1'b0;
    addr = 6'd3;
    repeat (5) tick();
    chk("idle_read_valid", 64'(read_valid), 64'd0);
    chk("idle_read_data", 64'(read_data), 64'd0);
    chk("idle_load_ready", 64'(load_ready), 64'd0);
    chk("idle_load_count", 64'(load_count), 64'd0);

    // Three-word load with load_last
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("l3_ready", 64'(load_ready), 64'd1);
    chk("l3_count0", 64'(load_count), 64'd0);
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data  = {4{4'(i + 1), 4'(i + 1)}};
      load_last  = (i == 2);
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    chk("l3_ready_drop", 64'(load_ready), 64'd0);
    chk("l3_count", 64'(load_count), 64'd3);
    chk("l3_done_early", 64'(load_done), 64'd0);
    chk("l3_valid_early", 64'(read_valid), 64'd0);
    tick();
    chk("l3_done", 64'(load_done), 64'd1);
    chk("l3_valid_first", 64'(read_valid), 64'd1);
    tick();
    chk("l3_done_once", 64'(load_done), 64'd0);
    for (int i = 0; i < 6; i++) run_reads(rd3[i], "rd3");

    // Full 64-word load auto-completes; a trailing valid word is dropped
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      load_valid = 1'b1;
      load_data  = 32'(i);
      tick();
    end
    chk("l64_ready_drop", 64'(load_ready), 64'd0);
    chk("l64_count", 64'(load_count), 64'd64);
    load_data = 32'hDEAD_BEEF;
    tick();
    load_valid = 1'b0;
    chk("l64_done", 64'(load_done), 64'd1);
    chk("l64_drop_count", 64'(load_count), 64'd64);
    for (int i = 0; i < 4; i++) run_reads(rd64[i], "rd64");

    // Reset in the middle of a four-word load
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1;
      load_data  = 32'hBBBB_0000 + 32'(i);
      tick();
    end
    load_valid = 1'b0;
    chk("mid_count", 64'(load_count), 64'd2);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(load_ready), 64'd0);
    chk("mid_rst_count", 64'(load_count), 64'd0);
    chk("mid_rst_valid", 64'(read_valid), 64'd0);
    chk("mid_rst_data", 64'(read_data), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    load_valid = 1'b1;
    load_last  = 1'b1;
    load_data  = 32'hAAAA_5555;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
    chk("reload_count", 64'(load_count), 64'd1);
    tick();
    chk("reload_done", 64'(load_done), 64'd1);
    addr = 6'd1;
    tick();
    chk("reload_a1_data", 64'(read_data), 64'd0);
    chk("reload_a1_valid", 64'(read_valid), 64'd1);
    addr = 6'd0;
    tick();
    chk("reload_a0_data", 64'(read_data), 64'hAAAA_5555);

    // load_start in RUN, then load_start ignored during LOAD
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("s_ready", 64'(load_ready), 64'd1);
    chk("s_valid_hold", 64'(read_valid), 64'd1);
    chk("s_count_clr", 64'(load_count), 64'd0);
    tick();
    chk("s_valid_fall", 64'(read_valid), 64'd0);
    chk("s_data_nop", 64'(read_data), 64'd0);
    load_valid = 1'b1;
    load_data  = 32'hC0DE_0001;
    tick();
    load_valid = 1'b0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("ign_start_count", 64'(load_count), 64'd1);
    chk("ign_start_ready", 64'(load_ready), 64'd1);
    load_valid = 1'b1;
    load_last  = 1'b1;
    load_data  = 32'hC0DE_0002;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
    chk("ign_final_count", 64'(load_count), 64'd2);
    addr = 6'd1;
    tick();
    chk("ign_done", 64'(load_done), 64'd1);
    tick();
    chk("ign_a1_data", 64'(read_data), 64'hC0DE_0002);
    chk("ign_a1_valid", 64'(read_valid), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
